// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the VGA raster generator.
// Defaults describe 800x600@60 (40 MHz pixel clock).
package vga_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic int count_width(input int total);
    int w;
    w = 1;
    while ((1 << w) < total) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: position counter plus a four-phase region tracker.
// wrap fires on the step that leaves BACK and returns to position 0.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 4,
  parameter int FP     = 1,
  parameter int SYNC   = 1,
  parameter int BP     = 1,
  parameter int W      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam logic [W-1:0] A_LAST = W'(ACTIVE - 1);
  localparam logic [W-1:0] F_LAST = W'(FP - 1);
  localparam logic [W-1:0] S_LAST = W'(SYNC - 1);
  localparam logic [W-1:0] B_LAST = W'(BP - 1);

  logic [W-1:0] in_cnt;
  logic [W-1:0] last_idx;
  phase_t       next_phase;
  logic         at_last;

  always_comb begin
    last_idx   = A_LAST;
    next_phase = PH_FRONT;
    unique case (phase)
      PH_ACTIVE: begin
        last_idx   = A_LAST;
        next_phase = PH_FRONT;
      end
      PH_FRONT: begin
        last_idx   = F_LAST;
        next_phase = PH_SYNC;
      end
      PH_SYNC: begin
        last_idx   = S_LAST;
        next_phase = PH_BACK;
      end
      PH_BACK: begin
        last_idx   = B_LAST;
        next_phase = PH_ACTIVE;
      end
    endcase
  end

  assign at_last = (in_cnt == last_idx);
  assign wrap    = step && at_last && (phase == PH_BACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      in_cnt <= '0;
      phase  <= PH_ACTIVE;
    end else if (step) begin
      count <= wrap ? '0 : count + W'(1);
      if (at_last) begin
        in_cnt <= '0;
        phase  <= next_phase;
      end else begin
        in_cnt <= in_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel enable.
// Outputs are registered decodes of the position held in the axis counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          sol,
  output logic          sof
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((1 << XW) < H_TOTAL) begin : g_xw_err
    $error("XW too narrow for H_TOTAL");
  end
  if ((1 << YW) < V_TOTAL) begin : g_yw_err
    $error("YW too narrow for V_TOTAL");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_len_err
    $error("all timing widths must be at least 1");
  end

  logic [XW-1:0] h_count;
  logic [YW-1:0] v_count;
  phase_t        h_phase;
  phase_t        v_phase;
  logic          h_wrap;
  logic          v_wrap;
  logic          line_start;
  logic          frame_start;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .W     (XW)
  ) u_h (
    .clk  (clk),
    .rst_n(rst_n),
    .step (en),
    .count(h_count),
    .phase(h_phase),
    .wrap (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .W     (YW)
  ) u_v (
    .clk  (clk),
    .rst_n(rst_n),
    .step (h_wrap),
    .count(v_count),
    .phase(v_phase),
    .wrap (v_wrap)
  );

  // line_start/frame_start flag that the held position is x==0 / (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      sol         <= 1'b0;
      sof         <= 1'b0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (en) begin
      hsync       <= (h_phase == PH_SYNC) ? HS_POL : !HS_POL;
      vsync       <= (v_phase == PH_SYNC) ? VS_POL : !VS_POL;
      de          <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      x           <= h_count;
      y           <= v_count;
      sol         <= line_start;
      sof         <= frame_start;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end else begin
      sol <= 1'b0;
      sof <= 1'b0;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/SVGA raster timing generator. It replaces the fixed-mode sync generator that currently sits behind the DCM output in the top level. Horizontal and vertical porch, sync and active widths, and sync polarities are set by parameters. A pixel-clock enable lets the block run off a faster system clock (e.g. 80 MHz with `en` every second cycle). It adds outputs the old block lacked: data-enable, pixel coordinates, and start-of-line and start-of-frame strobes for downstream pixel sources.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, horizontal sync width (pixels)
- `H_BP`, 88, horizontal back porch (pixels)
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vertical sync width (lines)
- `V_BP`, 23, vertical back porch (lines)
- `HS_POL`, 1, hsync asserted level (1 = active-high)
- `VS_POL`, 1, vsync asserted level
- `XW`, 11, x counter width; elaboration error if 2^XW < H_TOTAL
- `YW`, 10, y counter width; elaboration error if 2^YW < V_TOTAL
- `clk` in 1 — single clock, all logic rising-edge
- `rst_n` in 1 — asynchronous, active-low reset
- `en` in 1 — pixel enable; counters and outputs advance only when high
- `hsync` out 1 — horizontal sync, level per HS_POL
- `vsync` out 1 — vertical sync, level per VS_POL
- `de` out 1 — high while (x,y) is inside the active area
- `x` out XW — current horizontal count, 0..H_TOTAL-1
- `y` out YW — current vertical count, 0..V_TOTAL-1
- `sol` out 1 — one-clk strobe, start of every line (x==0)
- `sof` out 1 — one-clk strobe, start of frame (x==0, y==0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628). All parameters must be ≥1.
- Each axis has a phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - The phase changes when the in-phase counter reaches the phase length minus 1.
  - The horizontal axis steps on every `en`. The vertical axis steps only on the `en` that wraps horizontal BACK→ACTIVE.
- Horizontal regions:
  - ACTIVE: h < H_ACTIVE
  - SYNC: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - Vertical regions are analogous.
- Output decode:
  - hsync = HS_POL when h-phase is SYNC, else ~HS_POL. vsync likewise.
  - de = (h-phase ACTIVE) && (v-phase ACTIVE).
- Wrap-around: at (H_TOTAL-1, V_TOTAL-1) the next `en` returns to (0,0). No extra cycle and no skipped position.
- `en` low: counters, phases, hsync, vsync, de, x and y hold. sol and sof are forced to 0.

## Timing
- All outputs are registered. On a clk edge with `en`=1, the outputs take the decode of the current position (h,v), and the counters advance to the next position. Latency from counter to pins is 1 clk.
- sol/sof are high for exactly one clk, in the clk after the `en` that presented x=0 (and y=0 for sof). They are never stretched by `en` gaps.
- Reset (async assert, any time, including mid-line):
  - counters and phases go to 0/ACTIVE
  - hsync = ~HS_POL, vsync = ~VS_POL
  - de, x, y, sol, sof = 0
- After reset release, the first `en` presents (0,0) with de=1, sol=1 and sof=1.
- hsync changes only on `en` edges. Line period = H_TOTAL `en` pulses. Frame period = H_TOTAL·V_TOTAL `en` pulses.

## Structure
- Package `vga_pkg` holds:
  - the phase enum (ACTIVE, FRONT, SYNC, BACK)
  - default 800x600@60 timing constants
  - functions computing H_TOTAL/V_TOTAL and the required counter width
- Sub-module `vga_axis_counter` (parameters: ACTIVE, FP, SYNC, BP, W):
  - inputs: step; outputs: count, phase, wrap
  - instantiated twice. The horizontal wrap drives the vertical step.
- The top of the block does output decode, polarity and registering only.

## Test plan
- Reset: hold rst_n=0 with en toggling → hsync=0, vsync=0, de=0, x=0, y=0, sol=0, sof=0. Release, en=1 → next clk shows x=0, y=0, de=1, sof=1.
- Default line, en=1 always:
  - de high for 800 clks, then low for 256.
  - hsync rises at x=840 and falls at x=968.
  - sol is spaced exactly 1056 clks apart.
- Frame:
  - vsync high for exactly 4·1056 clks, starting at y=601.
  - sof is spaced 663168 clks apart.
  - y wraps from 627 to 0 together with x wrapping from 1055 to 0.
- en every second clk (80 MHz style):
  - sol spacing is 2112 clks, and each strobe is one clk wide.
  - all outputs hold during en=0 clks.
- Tiny mode H=4/1/2/1, V=3/1/1/1, HS_POL=0, VS_POL=0: check exhaustively over 3 frames (8×6 positions) against a reference model. hsync is low for x=5..6.
- Async reset asserted at x=500, y=300 → outputs return to reset values with no clk edge. After release, the raster restarts at (0,0) with sof.
